// File: rtl/uart_rx_pkg.sv
// Shared RX-path definitions: deserializer state encoding and bit-order constants
// used by both the deserializer and the RX FSM.
package uart_rx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } deser_state_e;

    localparam logic UART_LSB_FIRST = 1'b0;
    localparam logic UART_MSB_FIRST = 1'b1;

endpackage

// File: rtl/uart_rx_deser_p.sv
// Parametrised UART RX deserializer: runtime frame length and bit order, running
// parity, and a valid/ack holding register with sticky overrun detection.
module uart_rx_deser_p
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  deser_start,
    input  logic                  deser_New_bit,
    input  logic                  sampled_bit,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  cfg_msb_first,
    input  logic                  data_ack,
    output logic [DATA_WIDTH-1:0] P_DAta,
    output logic                  data_valid,
    output logic                  deser_done,
    output logic                  par_calc,
    output logic                  overrun,
    output logic                  busy
);

    deser_state_e          state_q;
    logic [DATA_WIDTH-1:0] assembly_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [LEN_W-1:0]      len_q;
    logic                  msb_q;
    logic                  par_q;

    logic                  bit_take;
    logic                  last_bit;
    logic [LEN_W-1:0]      len_eff;
    logic [DATA_WIDTH-1:0] assembly_nxt;
    logic                  par_nxt;

    // Out-of-range frame lengths fall back to the full word width.
    always_comb begin
        len_eff = cfg_len;
        if (cfg_len == '0 || cfg_len > LEN_W'(DATA_WIDTH)) begin
            len_eff = LEN_W'(DATA_WIDTH);
        end
    end

    // A start strobe always wins over a coincident data bit.
    assign bit_take = (state_q == ST_SHIFT) && deser_New_bit && !deser_start;
    assign last_bit = bit_take && (cnt_q == len_q - LEN_W'(1));
    assign par_nxt  = par_q ^ sampled_bit;

    always_comb begin
        assembly_nxt = assembly_q;
        if (msb_q == UART_MSB_FIRST) begin
            assembly_nxt = {assembly_q[DATA_WIDTH-2:0], sampled_bit};
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (cnt_q == LEN_W'(i)) begin
                    assembly_nxt[i] = sampled_bit;
                end
            end
        end
    end

    // Frame assembly FSM; the presented word and parity only move on completion.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            assembly_q <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            msb_q      <= UART_LSB_FIRST;
            par_q      <= 1'b0;
            P_DAta     <= '0;
            par_calc   <= 1'b0;
            deser_done <= 1'b0;
        end else begin
            deser_done <= 1'b0;
            if (deser_start) begin
                state_q    <= ST_SHIFT;
                assembly_q <= '0;
                cnt_q      <= '0;
                par_q      <= 1'b0;
                len_q      <= len_eff;
                msb_q      <= cfg_msb_first;
            end else if (bit_take) begin
                assembly_q <= assembly_nxt;
                par_q      <= par_nxt;
                cnt_q      <= cnt_q + LEN_W'(1);
                if (last_bit) begin
                    state_q    <= ST_IDLE;
                    P_DAta     <= assembly_nxt;
                    par_calc   <= par_nxt;
                    deser_done <= 1'b1;
                end
            end
        end
    end

    // Holding-register handshake: a fresh word re-asserts valid even when acked
    // in the same cycle, and overrun is sticky until the consumer acknowledges.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (last_bit) begin
                data_valid <= 1'b1;
            end else if (data_ack && data_valid) begin
                data_valid <= 1'b0;
            end

            if (last_bit && data_valid && !data_ack) begin
                overrun <= 1'b1;
            end else if (data_ack) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_uart_rx_deser_p.sv
// Directed self-checking bench for uart_rx_deser_p with DATA_WIDTH = 8.
module tb_uart_rx_deser_p;

    localparam int DW = 8;
    localparam int LW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          deser_start = 1'b0;
    logic          deser_New_bit = 1'b0;
    logic          sampled_bit = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_msb_first = 1'b0;
    logic          data_ack = 1'b0;
    logic [DW-1:0] P_DAta;
    logic          data_valid;
    logic          deser_done;
    logic          par_calc;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    int doneBase;

    uart_rx_deser_p #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .deser_start(deser_start), .deser_New_bit(deser_New_bit),
        .sampled_bit(sampled_bit), .cfg_len(cfg_len), .cfg_msb_first(cfg_msb_first),
        .data_ack(data_ack), .P_DAta(P_DAta), .data_valid(data_valid),
        .deser_done(deser_done), .par_calc(par_calc), .overrun(overrun), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (deser_done === 1'b1) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic startFrame(input int len, input logic msb, input logic withBit, input logic bitVal);
        deser_start   = 1'b1;
        cfg_len       = LW'(len);
        cfg_msb_first = msb;
        deser_New_bit = withBit;
        sampled_bit   = bitVal;
        tick();
        deser_start   = 1'b0;
        deser_New_bit = 1'b0;
    endtask

    // Sends bits[0..nbits-1] in transmission order; returns one cycle after the final strobe.
    task automatic applyStimulus(input logic [31:0] bits, input int nbits, input int gapMax, input logic ackOnLast);
        for (int i = 0; i < nbits; i++) begin
            deser_New_bit = 1'b1;
            sampled_bit   = bits[i];
            data_ack      = ackOnLast && (i == nbits - 1);
            tick();
            deser_New_bit = 1'b0;
            data_ack      = 1'b0;
            if (i < nbits - 1) repeat ($urandom_range(0, gapMax)) tick();
        end
    endtask

    task automatic ackWord();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    initial begin
        #12;
        checkOutput("rst_pdata", 32'(P_DAta), 32'h0);
        checkOutput("rst_valid", 32'(data_valid), 32'h0);
        checkOutput("rst_done", 32'(deser_done), 32'h0);
        checkOutput("rst_par", 32'(par_calc), 32'h0);
        checkOutput("rst_ovr", 32'(overrun), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        RST = 1'b1;
        tick();

        // Default LSB-first frame
        startFrame(8, 1'b0, 1'b0, 1'b0);
        checkOutput("f1_busy", 32'(busy), 32'h1);
        applyStimulus(32'b01001101, 8, 0, 1'b0);
        checkOutput("f1_done", 32'(deser_done), 32'h1);
        checkOutput("f1_pdata", 32'(P_DAta), 32'h4D);
        checkOutput("f1_par", 32'(par_calc), 32'h0);
        checkOutput("f1_valid", 32'(data_valid), 32'h1);
        checkOutput("f1_busy_end", 32'(busy), 32'h0);
        tick();
        checkOutput("f1_done_pulse", 32'(deser_done), 32'h0);
        ackWord();
        checkOutput("f1_ack_valid", 32'(data_valid), 32'h0);

        // MSB-first and LSB-first, len 5
        startFrame(5, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'b11001, 5, 3, 1'b0);
        checkOutput("msb5_pdata", 32'(P_DAta), 32'h13);
        checkOutput("msb5_par", 32'(par_calc), 32'h1);
        ackWord();
        startFrame(5, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'b11001, 5, 3, 1'b0);
        checkOutput("lsb5_pdata", 32'(P_DAta), 32'h19);
        checkOutput("lsb5_par", 32'(par_calc), 32'h1);
        ackWord();

        // Abort mid-frame, then full frame of ones
        doneBase = doneCount;
        startFrame(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'b101, 3, 2, 1'b0);
        startFrame(8, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_pdata_hold", 32'(P_DAta), 32'h19);
        checkOutput("abort_no_done", 32'(doneCount - doneBase), 32'h0);
        applyStimulus(32'hFF, 8, 2, 1'b0);
        tick();
        checkOutput("abort_done_count", 32'(doneCount - doneBase), 32'h1);
        checkOutput("abort_pdata", 32'(P_DAta), 32'hFF);
        checkOutput("abort_par", 32'(par_calc), 32'h0);
        ackWord();

        // Start with coincident bit: the bit must be dropped
        doneBase = doneCount;
        startFrame(4, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'b010, 3, 1, 1'b0);
        tick();
        checkOutput("drop_not_done", 32'(doneCount - doneBase), 32'h0);
        checkOutput("drop_busy", 32'(busy), 32'h1);
        applyStimulus(32'b1, 1, 0, 1'b0);
        checkOutput("drop_pdata", 32'(P_DAta), 32'hA);
        ackWord();

        // Overrun and ack-to-clear
        startFrame(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'hA5, 8, 1, 1'b0);
        checkOutput("ovr_first_clear", 32'(overrun), 32'h0);
        startFrame(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h3C, 8, 1, 1'b0);
        checkOutput("ovr_set", 32'(overrun), 32'h1);
        checkOutput("ovr_pdata", 32'(P_DAta), 32'h3C);
        checkOutput("ovr_valid", 32'(data_valid), 32'h1);
        ackWord();
        checkOutput("ovr_ack_valid", 32'(data_valid), 32'h0);
        checkOutput("ovr_ack_clear", 32'(overrun), 32'h0);

        // Ack coinciding with completion: no overrun
        startFrame(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h5A, 8, 0, 1'b0);
        startFrame(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0F, 8, 0, 1'b1);
        checkOutput("coack_ovr", 32'(overrun), 32'h0);
        checkOutput("coack_valid", 32'(data_valid), 32'h1);
        checkOutput("coack_pdata", 32'(P_DAta), 32'h0F);
        ackWord();

        // Length coercion with idle gaps
        startFrame(0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h96, 8, 20, 1'b0);
        checkOutput("len0_pdata", 32'(P_DAta), 32'h96);
        checkOutput("len0_par", 32'(par_calc), 32'h0);
        checkOutput("len0_busy", 32'(busy), 32'h0);
        ackWord();
        startFrame(9, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h6B, 8, 20, 1'b0);
        checkOutput("len9_pdata", 32'(P_DAta), 32'h6B);
        checkOutput("len9_par", 32'(par_calc), 32'h1);
        checkOutput("len9_valid", 32'(data_valid), 32'h1);

        // Async reset mid-frame while a word is still pending
        startFrame(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'b1011, 4, 0, 1'b0);
        #3 RST = 1'b0;
        #1;
        checkOutput("arst_pdata", 32'(P_DAta), 32'h0);
        checkOutput("arst_valid", 32'(data_valid), 32'h0);
        checkOutput("arst_par", 32'(par_calc), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        #2 RST = 1'b1;
        tick();
        startFrame(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h81, 8, 2, 1'b0);
        checkOutput("post_rst_pdata", 32'(P_DAta), 32'h81);
        checkOutput("post_rst_par", 32'(par_calc), 32'h0);
        checkOutput("post_rst_ovr", 32'(overrun), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
